// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display path: scan-state encoding
// and the digit-index width helper.
package display_pkg;

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t SCAN_IDLE   = 2'd0;
    localparam scan_state_t SCAN_ACTIVE = 2'd1;
    localparam scan_state_t SCAN_GUARD  = 2'd2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_scan_next.sv
// Circular priority finder: first unmasked digit after cur_idx, wrapping round
// so that cur_idx itself is the last candidate considered.
module digit_scan_next
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = idx_width(NUM_DIGITS)
) (
    input  logic [IDX_W-1:0]      cur_idx,
    input  logic [NUM_DIGITS-1:0] mask,
    output logic [IDX_W-1:0]      next_idx,
    output logic                  none_valid
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        next_idx   = '0;
        none_valid = 1'b1;
        cand       = '0;
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            cand = IDX_W'((int'(cur_idx) + k) % NUM_DIGITS);
            if (!mask[cand]) begin
                next_idx   = cand;
                none_valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/digit_scanner.sv
// Time-multiplexed N-digit anode scanner with programmable dwell, guard gaps,
// per-digit skip mask, selectable polarity and a frame-start strobe.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   SCAN_IDLE   | scan stopped, all digits off
//   SCAN_ACTIVE | digit idx driven for DWELL cycles
//   SCAN_GUARD  | all digits off between digits, or waiting for an unmasked one
module digit_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 50000,
    parameter int GUARD      = 500,
    parameter bit ACTIVE_LOW = 1'b0,
    localparam int IDX_W     = idx_width(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] skip_mask,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_start
);

    localparam int MAX_CNT = (DWELL > GUARD) ? DWELL : GUARD;
    localparam int CNT_W   = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'((DWELL > 0) ? DWELL - 1 : 0);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [CNT_W-1:0] RETRY_LOAD = CNT_W'(((GUARD > 1) ? GUARD : 1) - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || DWELL < 1 || GUARD < 0) begin : g_bad_params
        $error("digit_scanner: NUM_DIGITS and DWELL must be >= 1, GUARD >= 0");
    end

    scan_state_t       state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic              fresh;
    logic              fs_q;

    logic [IDX_W-1:0]  search_from;
    logic [IDX_W-1:0]  next_idx;
    logic              none_valid;
    logic              in_active;
    logic              in_guard;
    logic              expired;
    logic              advance;

    assign in_active = (state == SCAN_ACTIVE);
    assign in_guard  = (state == SCAN_GUARD);
    assign expired   = (cnt == '0);

    // From IDLE the search must start at digit 0, so pretend the last digit was driven.
    assign search_from = (in_active || in_guard) ? idx : LAST_IDX;

    digit_scan_next #(
        .NUM_DIGITS (NUM_DIGITS),
        .IDX_W      (IDX_W)
    ) u_next (
        .cur_idx    (search_from),
        .mask       (skip_mask),
        .next_idx   (next_idx),
        .none_valid (none_valid)
    );

    assign advance = !(in_active || in_guard)
                   || (expired && (in_guard || GUARD == 0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SCAN_IDLE;
            idx   <= '0;
            cnt   <= '0;
            fresh <= 1'b1;
            fs_q  <= 1'b0;
        end else begin
            fs_q <= 1'b0;
            if (!enable) begin
                state <= SCAN_IDLE;
                idx   <= '0;
                cnt   <= '0;
                fresh <= 1'b1;
            end else if (advance) begin
                if (none_valid) begin
                    state <= SCAN_GUARD;
                    cnt   <= RETRY_LOAD;
                end else begin
                    state <= SCAN_ACTIVE;
                    idx   <= next_idx;
                    cnt   <= DWELL_LOAD;
                    fresh <= 1'b0;
                    fs_q  <= fresh | (next_idx <= idx);
                end
            end else if (in_active && expired) begin
                state <= SCAN_GUARD;
                cnt   <= GUARD_LOAD;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    logic [NUM_DIGITS-1:0] sel_raw;

    always_comb begin
        sel_raw = '0;
        if (in_active) begin
            sel_raw[idx] = 1'b1;
        end
    end

    assign digit_sel   = ACTIVE_LOW ? ~sel_raw : sel_raw;
    assign digit_idx   = in_active ? idx : '0;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Bench for digit_scanner: slot-based reference model checked every cycle,
// plus directed literal checks of the scan sequences.
module tb_digit_scanner;

    localparam int N = 4;
    localparam int D = 3;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       en2;
    logic [3:0] skip_mask;
    logic [3:0] digit_sel, digit_sel2;
    logic [1:0] digit_idx, digit_idx2;
    logic       frame_start, frame_start2;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    digit_scanner #(.NUM_DIGITS(N), .DWELL(D), .GUARD(G), .ACTIVE_LOW(1'b0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .skip_mask   (skip_mask),
        .digit_sel   (digit_sel),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    digit_scanner #(.NUM_DIGITS(4), .DWELL(3), .GUARD(0), .ACTIVE_LOW(1'b1)) dut_al (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (en2),
        .skip_mask   (4'b0000),
        .digit_sel   (digit_sel2),
        .digit_idx   (digit_idx2),
        .frame_start (frame_start2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the scan is a sequence of slots (a digit for D cycles,
    // a dark gap for G cycles); m_left counts the cycles left in the slot.
    bit m_run, m_on, m_fresh, m_fs;
    int m_digit, m_left;

    function automatic void m_pick(input int start);
        int cand;
        cand = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (start + k) % N;
            if (!skip_mask[c] && cand < 0) cand = c;
        end
        if (cand < 0) begin
            m_on   = 1'b0;
            m_left = (G > 1) ? G : 1;
        end else begin
            m_fs    = m_fresh || (cand <= m_digit);
            m_fresh = 1'b0;
            m_digit = cand;
            m_on    = 1'b1;
            m_left  = D;
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 0; m_on = 0; m_digit = 0; m_fs = 0; m_fresh = 1; m_left = 0;
        end else begin
            m_fs = 1'b0;
            if (!enable) begin
                m_run = 0; m_on = 0; m_digit = 0; m_fresh = 1; m_left = 0;
            end else if (!m_run) begin
                m_run = 1'b1;
                m_pick(0);
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_on && G > 0) begin
                        m_on   = 1'b0;
                        m_left = G;
                    end else begin
                        m_pick(m_digit + 1);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_sel", digit_sel, m_on ? (32'd1 << m_digit) : 32'd0);
            check("model_idx", digit_idx, m_on ? m_digit : 0);
            check("model_fs", frame_start, m_fs);
        end
    end

    logic [3:0] basic_exp [17] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
                                   4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1};
    logic [3:0] al_exp [13] = '{4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hB, 4'hB, 4'hB,
                                4'h7, 4'h7, 4'h7, 4'hE};

    initial begin
        int bad_cnt, fs_cnt, found, found_fs;
        reset_n = 1'b0; enable = 1'b0; en2 = 1'b0; skip_mask = 4'b0000;
        repeat (2) @(negedge clk);
        check("reset_sel", digit_sel, 4'h0);
        check("reset_idx", digit_idx, 0);
        check("reset_fs", frame_start, 0);
        check("reset_sel_al", digit_sel2, 4'hF);
        reset_n = 1'b1;
        chk_on  = 1'b1;

        // basic scan
        @(negedge clk); enable = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            check("basic_sel", digit_sel, basic_exp[c-1]);
            check("basic_fs", frame_start, (c == 1 || c == 17) ? 1 : 0);
        end

        // enable dropped while digit 1 is driven
        enable = 1'b0;
        @(negedge clk); enable = 1'b1;
        repeat (6) @(negedge clk);
        check("drop_pre_sel", digit_sel, 4'h2);
        enable = 1'b0;
        @(negedge clk);
        check("drop_sel", digit_sel, 4'h0);
        check("drop_idx", digit_idx, 0);
        @(negedge clk); enable = 1'b1;
        @(negedge clk);
        check("restart_sel", digit_sel, 4'h1);
        check("restart_fs", frame_start, 1);

        // skip mask 0100
        enable = 1'b0; skip_mask = 4'b0100;
        @(negedge clk); enable = 1'b1;
        bad_cnt = 0; fs_cnt = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (digit_sel == 4'b0100) bad_cnt++;
            if (frame_start) fs_cnt++;
            if (c == 1)  check("skip_c1_idx", digit_idx, 0);
            if (c == 5)  check("skip_c5_idx", digit_idx, 1);
            if (c == 9)  check("skip_c9_idx", digit_idx, 3);
            if (c == 13) check("skip_c13_fs", frame_start, 1);
        end
        check("skip_never_digit2", bad_cnt, 0);
        check("skip_frames_in_24", fs_cnt, 2);

        // all masked, then release digit 2
        enable = 1'b0; skip_mask = 4'b1111;
        @(negedge clk); enable = 1'b1;
        bad_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (digit_sel != 4'h0 || frame_start) bad_cnt++;
        end
        check("allmask_dark", bad_cnt, 0);
        skip_mask = 4'b1011;
        found = 0; found_fs = 0;
        for (int c = 0; c < G + 1 && found == 0; c++) begin
            @(negedge clk);
            if (digit_sel == 4'b0100) begin
                found = 1;
                found_fs = frame_start;
            end
        end
        check("unmask_found", found, 1);
        check("unmask_fs", found_fs, 1);

        // randomized scan
        skip_mask = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            if ($urandom_range(0, 24) == 0) skip_mask = 4'($urandom_range(0, 15));
        end

        // asynchronous reset in the middle of a dwell
        enable = 1'b0; skip_mask = 4'b0000;
        @(negedge clk); enable = 1'b1;
        repeat (2) @(negedge clk);
        check("prereset_sel", digit_sel, 4'h1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_sel", digit_sel, 4'h0);
        check("async_idx", digit_idx, 0);
        check("async_fs", frame_start, 0);
        enable = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", digit_sel, 4'h0);
        enable = 1'b1;
        @(negedge clk);
        check("post_reset_start", digit_sel, 4'h1);
        check("post_reset_fs", frame_start, 1);

        // active-low, zero-guard instance
        en2 = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            check("al_sel", digit_sel2, al_exp[c-1]);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/digit_scanner.md
# digit_scanner

Parametrised time-multiplexed digit scanner for the reaction-timer seven-segment display path. It generalises the fixed four-digit one-hot rotator to N digits and adds:
- a programmable dwell time per digit and anti-ghosting guard gaps;
- per-digit skip masking and selectable output polarity;
- a frame-start strobe for the segment-data mux.

It sits between the display controller (enable, mask) and the digit-anode pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (>= 1)
- DWELL, 50000, clock cycles each digit is driven (>= 1)
- GUARD, 500, clock cycles with all digits off between digits (>= 0)
- ACTIVE_LOW, 0, 1 = digit_sel driven active-low (common-anode boards)
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  scan runs while high
- skip_mask  in  NUM_DIGITS  bit i set = digit i never driven
- digit_sel  out  NUM_DIGITS  one-hot digit drive (polarity per ACTIVE_LOW)
- digit_idx  out  max(1,$clog2(NUM_DIGITS))  index of the driven digit; 0 when none
- frame_start  out  1  one-cycle pulse on first ACTIVE cycle of each frame

## Operation
- States: IDLE, ACTIVE, GUARD. Outputs are Moore, decoded from registered state/index.
- Reset: state IDLE, index 0, counter 0. Outputs: digit_sel all-off (0 or all-ones per ACTIVE_LOW), digit_idx 0, frame_start 0.
- IDLE → next digit when enable is sampled high. The next digit is the lowest unmasked index starting from 0. Go to ACTIVE on it, or to GUARD if all digits are masked.
- ACTIVE: exactly DWELL cycles with digit_sel one-hot at index.
  - When DWELL expires, go to GUARD if GUARD > 0.
  - Otherwise go directly to the next digit.
- GUARD: max(GUARD,1) cycles when entered because all digits are masked; otherwise exactly GUARD cycles. digit_sel is all-off throughout. On expiry, go to the next digit.
- Next-digit selection: circular search from index+1 for the first index with skip_mask = 0. The current index itself is found last, so a single unmasked digit repeats.
  - skip_mask is sampled only on the cycle the selection is made.
  - If no digit is unmasked, go to or stay in GUARD, reload the counter and retry.
- frame_start: high in the first ACTIVE cycle whose index is ≤ the previously driven index, or in the first ACTIVE cycle after IDLE.
- enable sampled low in any state → IDLE on the next edge. digit_sel is off the following cycle and any dwell in progress is abandoned.
- reset_n asserted mid-scan → outputs go to reset values immediately (asynchronous).
- Counter width: $clog2(max(DWELL,GUARD)+1). The counter loads DWELL-1 / GUARD-1 on state entry, counts down, and expires at 0.

## Timing
- Latency: enable high sampled at edge k → digit_sel active from cycle k+1.
- Frame period = U·(DWELL+GUARD) cycles, where U = number of unmasked digits.
- At most one digit_sel bit is active in any cycle. There is never an overlap at a digit change.
- GUARD = 0: successive digits are back-to-back. The index changes on the edge where the dwell expires.
- Mask change during ACTIVE: the current dwell completes unchanged. The new mask takes effect at the next selection.

## Structure
- Shared package display_pkg holds:
  - the scan-state typedef (IDLE, ACTIVE, GUARD);
  - a function computing the index width.
- Sub-module digit_scan_next: combinational circular priority finder (current index, mask → next index, none_valid). It is reused by the segment-data mux.
- Parameter legality (NUM_DIGITS ≥ 1, DWELL ≥ 1) is checked at elaboration.

## Test plan
Bench parameters: NUM_DIGITS=4, DWELL=3, GUARD=1, mask 0, unless stated otherwise.
- **Basic scan:** enable high at edge 0.
  - digit_sel 0001 in cycles 1–3, 0000 in cycle 4, 0010 in cycles 5–7, and so on; 1000 in cycles 13–15.
  - Back to 0001 at cycle 17.
  - frame_start pulses at cycles 1 and 17 only.
- **Skip mask 4'b0100:** index sequence is 0, 1, 3, 0. digit_sel never shows 0100. Frame period is 12 cycles.
- **enable dropped in cycle 6** (digit 1 active): digit_sel 0000 and digit_idx 0 from cycle 7. Re-enabling restarts at digit 0 with frame_start.
- **All masked (4'b1111):** digit_sel stays 0000 and frame_start stays 0 indefinitely. Clearing bit 2 → digit_sel 0100 within GUARD+1 cycles, with frame_start.
- **ACTIVE_LOW=1, GUARD=0:**
  - Reset gives digit_sel 1111.
  - Scan shows 1110, 1101, 1011, 0111 back-to-back, 3 cycles each.
- **Async reset mid-dwell:** assert reset_n low between edges → outputs reach reset values before the next edge. Release → IDLE until enable is sampled high.
